// File: rtl/wide_alu_sequencer_pkg.sv
// Shared exe_cmd codes, status bit indices and the command-map bundle
// used by the 64-bit two-pass sequencer.
package wide_alu_sequencer_pkg;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_NOP = 4'b0000;
    localparam cmd_t CMD_MOV = 4'b0001;
    localparam cmd_t CMD_ADD = 4'b0010;
    localparam cmd_t CMD_ADC = 4'b0011;
    localparam cmd_t CMD_SUB = 4'b0100;
    localparam cmd_t CMD_SBC = 4'b0101;
    localparam cmd_t CMD_AND = 4'b0110;
    localparam cmd_t CMD_ORR = 4'b0111;
    localparam cmd_t CMD_EOR = 4'b1000;
    localparam cmd_t CMD_MVN = 4'b1001;

    localparam int ST_C = 3;
    localparam int ST_N = 2;
    localparam int ST_V = 1;
    localparam int ST_Z = 0;

    typedef struct packed {
        cmd_t alu_cmd;
        logic is_arith;
        logic is_sub;
        logic legal;
    } cmd_map_t;

    function automatic logic uses_carry(cmd_t cmd);
        return (cmd == CMD_ADC) || (cmd == CMD_SBC);
    endfunction

endpackage

// File: rtl/wide_alu_sequencer_if.sv
// Request, response and ALU-drive bundle of the 64-bit sequencer.
// slave is the sequencer side, master the requester/ALU side.
interface wide_alu_sequencer_if #(
    parameter int W     = 32,
    parameter int CMD_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [CMD_W-1:0] req_cmd;
    logic [2*W-1:0]   req_a;
    logic [2*W-1:0]   req_b;
    logic             req_c;
    logic [W-1:0]     alu_val_1;
    logic [W-1:0]     alu_val_2;
    logic             alu_c_in;
    logic [CMD_W-1:0] alu_exe_cmd;
    logic [W-1:0]     alu_result;
    logic [3:0]       alu_status;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_result;
    logic [3:0]       rsp_status;
    logic             rsp_illegal;

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, req_c,
        output req_ready,
        output alu_val_1, alu_val_2, alu_c_in, alu_exe_cmd,
        input  alu_result, alu_status,
        output rsp_valid, rsp_result, rsp_status, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_cmd, req_a, req_b, req_c,
        input  req_ready,
        input  alu_val_1, alu_val_2, alu_c_in, alu_exe_cmd,
        output alu_result, alu_status,
        input  rsp_valid, rsp_result, rsp_status, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/wide_alu_sequencer_cmd_map.sv
// Maps a 64-bit op and pass (LO/HI) onto the 32-bit ALU command;
// the HI pass of ADD/SUB becomes the carry-chained ADC/SBC.
module wide_cmd_map
    import wide_alu_sequencer_pkg::*;
(
    input  cmd_t     cmd,
    input  logic     hi,
    output cmd_map_t map
);
    always_comb begin
        map = '0;
        unique case (1'b1)
            (cmd == CMD_ADD), (cmd == CMD_ADC): begin
                map.alu_cmd  = hi ? CMD_ADC : cmd;
                map.is_arith = 1'b1;
                map.legal    = 1'b1;
            end
            (cmd == CMD_SUB), (cmd == CMD_SBC): begin
                map.alu_cmd  = hi ? CMD_SBC : cmd;
                map.is_arith = 1'b1;
                map.is_sub   = 1'b1;
                map.legal    = 1'b1;
            end
            (cmd == CMD_MOV), (cmd == CMD_AND), (cmd == CMD_ORR),
            (cmd == CMD_EOR), (cmd == CMD_MVN): begin
                map.alu_cmd = cmd;
                map.legal   = 1'b1;
            end
            default: map = '0;
        endcase
    end
endmodule

// File: rtl/wide_alu_sequencer.sv
// Two-pass 64-bit op sequencer over the shared 32-bit EXE ALU:
// LO pass on low words, HI pass chains the carry, then a held response.
module wide_alu_sequencer
    import wide_alu_sequencer_pkg::*;
#(
    parameter int W     = 32,
    parameter int CMD_W = 4
) (
    input logic                 clk,
    input logic                 rst,
    wide_alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic [CMD_W-1:0] cmd_q;
    logic [2*W-1:0]   a_q;
    logic [2*W-1:0]   b_q;
    logic             c_q;
    logic [W-1:0]     lo_res;
    logic             lo_c;
    logic             lo_z;
    logic             rsp_valid;
    logic [2*W-1:0]   rsp_result;
    logic [3:0]       rsp_status;
    logic             rsp_illegal;

    cmd_t     map_cmd;
    cmd_map_t map;

    assign map_cmd = (state == IDLE) ? bus.req_cmd : cmd_q;

    wide_cmd_map u_map (
        .cmd (map_cmd),
        .hi  (state == HI),
        .map (map)
    );

    assign bus.req_ready   = (state == IDLE);
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_result  = rsp_result;
    assign bus.rsp_status  = rsp_status;
    assign bus.rsp_illegal = rsp_illegal;

    always_comb begin
        bus.alu_val_1   = '0;
        bus.alu_val_2   = '0;
        bus.alu_c_in    = 1'b0;
        bus.alu_exe_cmd = '0;
        unique case (state)
            LO: begin
                bus.alu_val_1   = a_q[W-1:0];
                bus.alu_val_2   = b_q[W-1:0];
                bus.alu_c_in    = uses_carry(cmd_q) & c_q;
                bus.alu_exe_cmd = map.alu_cmd;
            end
            HI: begin
                bus.alu_val_1   = a_q[2*W-1:W];
                bus.alu_val_2   = b_q[2*W-1:W];
                // ALU C after subtract is a borrow; SBC wants 1 = no borrow
                bus.alu_c_in    = map.is_arith & (map.is_sub ? ~lo_c : lo_c);
                bus.alu_exe_cmd = map.alu_cmd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            lo_res      <= '0;
            lo_c        <= 1'b0;
            lo_z        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_status  <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid) begin
                    cmd_q <= bus.req_cmd;
                    a_q   <= bus.req_a;
                    b_q   <= bus.req_b;
                    c_q   <= bus.req_c;
                    if (map.legal) begin
                        state <= LO;
                    end else begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_result  <= '0;
                        rsp_status  <= '0;
                        rsp_illegal <= 1'b1;
                    end
                end
                LO: begin
                    lo_res <= bus.alu_result;
                    lo_c   <= bus.alu_status[ST_C];
                    lo_z   <= bus.alu_status[ST_Z];
                    state  <= HI;
                end
                HI: begin
                    rsp_result  <= {bus.alu_result, lo_res};
                    rsp_status  <= {map.is_arith & bus.alu_status[ST_C],
                                    bus.alu_status[ST_N],
                                    map.is_arith & bus.alu_status[ST_V],
                                    lo_z & bus.alu_status[ST_Z]};
                    rsp_illegal <= 1'b0;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Directed bench for wide_alu_sequencer with a behavioural 32-bit ALU;
// inputs driven and outputs sampled on the falling edge.
module tb_wide_alu_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wide_alu_sequencer_if #(.W(32), .CMD_W(4)) bus ();

    wide_alu_sequencer #(.W(32), .CMD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference 32-bit ALU; C after SUB/SBC is a borrow (1 = borrow)
    logic [32:0] sum;
    logic [31:0] v1, v2;
    logic        av;
    logic        ac;
    always_comb begin
        v1  = bus.alu_val_1;
        v2  = bus.alu_val_2;
        sum = '0;
        av  = 1'b0;
        ac  = 1'b0;
        case (bus.alu_exe_cmd)
            4'b0001: sum = {1'b0, v2};
            4'b0010: sum = {1'b0, v1} + {1'b0, v2};
            4'b0011: sum = {1'b0, v1} + {1'b0, v2} + {32'd0, bus.alu_c_in};
            4'b0100: sum = {1'b0, v1} - {1'b0, v2};
            4'b0101: sum = {1'b0, v1} - {1'b0, v2} - {32'd0, ~bus.alu_c_in};
            4'b0110: sum = {1'b0, v1 & v2};
            4'b0111: sum = {1'b0, v1 | v2};
            4'b1000: sum = {1'b0, v1 ^ v2};
            4'b1001: sum = {1'b0, ~v2};
            default: sum = '0;
        endcase
        case (bus.alu_exe_cmd)
            4'b0010, 4'b0011: begin
                ac = sum[32];
                av = (v1[31] == v2[31]) && (sum[31] != v1[31]);
            end
            4'b0100, 4'b0101: begin
                ac = sum[32];
                av = (v1[31] != v2[31]) && (sum[31] != v1[31]);
            end
            default: ;
        endcase
        bus.alu_result = sum[31:0];
        bus.alu_status = {ac, sum[31], av, sum[31:0] == 32'd0};
    end

    task automatic run_op(input logic [3:0] cmd, input logic [63:0] a,
                          input logic [63:0] b, input logic c,
                          output logic [63:0] res, output logic [3:0] st,
                          output logic ill, output int lat,
                          output logic hi_cin);
        lat    = 0;
        hi_cin = 1'b0;
        bus.req_cmd   = cmd;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_c     = c;
        bus.req_valid = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) bus.req_valid = 1'b0;
            if (n == 2) hi_cin = bus.alu_c_in;
            if (bus.rsp_valid) begin
                lat = n;
                break;
            end
        end
        res = bus.rsp_result;
        st  = bus.rsp_status;
        ill = bus.rsp_illegal;
        if (lat != 0) begin
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1/0",
                     bus.req_ready, bus.rsp_valid);
        end
        total++;
        if (bus.rsp_result !== 64'd0 || bus.rsp_status !== 4'd0 ||
            bus.rsp_illegal !== 1'b0 || bus.alu_exe_cmd !== 4'd0) begin
            bad++;
            $display("FAIL reset_regs: res=%h st=%b ill=%b cmd=%b want 0",
                     bus.rsp_result, bus.rsp_status, bus.rsp_illegal,
                     bus.alu_exe_cmd);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [3:0] cmd,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic c, input logic [63:0] exp_r,
                            input logic [3:0] exp_s);
        logic [63:0] r;
        logic [3:0]  s;
        logic        ill, hc;
        int          lat;
        run_op(cmd, a, b, c, r, s, ill, lat, hc);
        total++;
        if (r !== exp_r || s !== exp_s || ill !== 1'b0 || lat != 3) begin
            bad++;
            $display("FAIL %s: res=%h st=%b ill=%b lat=%0d want %h %b 0 3",
                     name, r, s, ill, lat, exp_r, exp_s);
        end
    endtask

    task automatic test_add_carry();
        logic [63:0] r;
        logic [3:0]  s;
        logic        ill, hc;
        int          lat;
        run_op(4'b0010, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
               r, s, ill, lat, hc);
        total++;
        if (r !== 64'h0000_0001_0000_0000) begin
            bad++;
            $display("FAIL add_res: got %h want 0000000100000000", r);
        end
        total++;
        if (s !== 4'b0000 || ill !== 1'b0) begin
            bad++;
            $display("FAIL add_st: got %b ill=%b want 0000 0", s, ill);
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL add_latency: got %0d want 3", lat);
        end
        total++;
        if (hc !== 1'b1) begin
            bad++;
            $display("FAIL add_hi_cin: got %b want 1", hc);
        end
    endtask

    task automatic test_sub_borrow();
        logic [63:0] r;
        logic [3:0]  s;
        logic        ill, hc;
        int          lat;
        run_op(4'b0100, 64'h0000_0001_0000_0000, 64'd1, 1'b0,
               r, s, ill, lat, hc);
        total++;
        if (r !== 64'h0000_0000_FFFF_FFFF || s !== 4'b0000) begin
            bad++;
            $display("FAIL sub_res: got %h %b want 00000000ffffffff 0000",
                     r, s);
        end
        total++;
        if (hc !== 1'b0) begin
            bad++;
            $display("FAIL sub_hi_cin: got %b want 0", hc);
        end
    endtask

    task automatic test_add_overflow();
        check_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                 64'h8000_0000_0000_0000, 4'b0110);
    endtask

    task automatic test_logic();
        check_op("and_zero", 4'b0110, 64'hFFFF_0000_0000_FFFF,
                 64'h0000_FFFF_FFFF_0000, 1'b0, 64'd0, 4'b0001);
        check_op("eor_self", 4'b1000, 64'hDEAD_BEEF_0123_4567,
                 64'hDEAD_BEEF_0123_4567, 1'b0, 64'd0, 4'b0001);
        check_op("orr", 4'b0111, 64'h1234_0000_0000_00F0,
                 64'h0000_5678_0F00_0000, 1'b0,
                 64'h1234_5678_0F00_00F0, 4'b0000);
        check_op("mov", 4'b0001, 64'h1111_2222_3333_4444,
                 64'h8000_0000_0000_0000, 1'b1,
                 64'h8000_0000_0000_0000, 4'b0100);
        check_op("mvn", 4'b1001, 64'h5555_5555_5555_5555, 64'd0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
    endtask

    task automatic test_carry_ops();
        check_op("adc", 4'b0011, 64'd1, 64'd1, 1'b1, 64'd3, 4'b0000);
        check_op("adc_c0", 4'b0011, 64'd1, 64'd1, 1'b0, 64'd2, 4'b0000);
        check_op("sbc_borrow_in", 4'b0101, 64'd5, 64'd3, 1'b0,
                 64'd1, 4'b0000);
        check_op("sbc_wrap", 4'b0101, 64'd0, 64'd0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 4'b1100);
        check_op("sub_zero", 4'b0100, 64'd5, 64'd5, 1'b0, 64'd0, 4'b0001);
        check_op("sub_neg", 4'b0100, 64'd0, 64'd1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 4'b1100);
    endtask

    task automatic test_backpressure();
        logic [63:0] r0;
        int          seen;
        seen = 0;
        bus.req_cmd   = 4'b0010;
        bus.req_a     = 64'd1;
        bus.req_b     = 64'd2;
        bus.req_c     = 1'b0;
        bus.req_valid = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        r0 = bus.rsp_result;
        total++;
        if (seen == 0 || r0 !== 64'd3) begin
            bad++;
            $display("FAIL bp_first: seen=%0d res=%h want 1 3", seen, r0);
        end
        bus.req_cmd   = 4'b0111;
        bus.req_a     = 64'h1234_0000_0000_00F0;
        bus.req_b     = 64'h0000_5678_0F00_0000;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'd3 ||
                bus.rsp_status !== 4'd0 || bus.req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: v=%b res=%h st=%b rdy=%b want 1 3 0 0",
                         bus.rsp_valid, bus.rsp_result, bus.rsp_status,
                         bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: v=%b rdy=%b want 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_second_accept: rdy=%b want 0", bus.req_ready);
        end
        seen = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = n;
                break;
            end
        end
        total++;
        if (seen != 2 || bus.rsp_result !== 64'h1234_5678_0F00_00F0) begin
            bad++;
            $display("FAIL bp_second: wait=%0d res=%h want 2 123456780f0000f0",
                     seen, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int hits;
        int wrong;
        hits  = 0;
        wrong = 0;
        bus.req_cmd   = 4'b0010;
        bus.req_a     = 64'd1;
        bus.req_b     = 64'd2;
        bus.req_c     = 1'b0;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                hits++;
                if (bus.rsp_result !== 64'd3) wrong++;
            end
        end
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.rsp_ready = 1'b0;
        total++;
        if (hits != 3 || wrong != 0) begin
            bad++;
            $display("FAIL b2b_rate: rsp=%0d wrong=%0d want 3 0", hits, wrong);
        end
    endtask

    task automatic test_reset_mid();
        int hits;
        hits = 0;
        bus.req_cmd   = 4'b0010;
        bus.req_a     = 64'd7;
        bus.req_b     = 64'd8;
        bus.req_c     = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.alu_exe_cmd !== 4'b0011) begin
            bad++;
            $display("FAIL mid_in_hi: cmd=%b want 0011", bus.alu_exe_cmd);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
            bus.rsp_result !== 64'd0 || bus.alu_exe_cmd !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset: v=%b rdy=%b res=%h cmd=%b want 0 1 0 0",
                     bus.rsp_valid, bus.req_ready, bus.rsp_result,
                     bus.alu_exe_cmd);
        end
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) hits++;
        end
        bus.rsp_ready = 1'b0;
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL mid_no_rsp: got %0d responses want 0", hits);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] r;
        logic [3:0]  s;
        logic        ill, hc;
        int          lat;
        run_op(4'b1111, 64'h1234, 64'h5678, 1'b1, r, s, ill, lat, hc);
        total++;
        if (ill !== 1'b1 || r !== 64'd0 || s !== 4'd0) begin
            bad++;
            $display("FAIL illegal_rsp: ill=%b res=%h st=%b want 1 0 0",
                     ill, r, s);
        end
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL illegal_latency: got %0d want 1", lat);
        end
        check_op("after_illegal", 4'b0010, 64'd4, 64'd5, 1'b0,
                 64'd9, 4'b0000);
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_add_overflow();
        test_logic();
        test_carry_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
